// File: rtl/mul8_share_sched.sv
// Two-requester 8x8 unsigned multiplier built on one shared 4x4 nibble multiplier.
// Each accepted operation runs four partial-product steps, then holds its result until it is taken.
module mul8_share_sched #(
    parameter int unsigned TAG_W = 4,
    parameter bit          RR_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [7:0]       req0_a_i,
    input  logic [7:0]       req0_b_i,
    input  logic [TAG_W-1:0] req0_tag_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [7:0]       req1_a_i,
    input  logic [7:0]       req1_b_i,
    input  logic [TAG_W-1:0] req1_tag_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [15:0]      res_p_o,
    output logic             res_src_o,
    output logic [TAG_W-1:0] res_tag_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {StIdle, StStep, StDone} state_e;

    state_e             state_q, state_d;
    logic [7:0]         a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               src_q, src_d;
    logic               last_gnt_q, last_gnt_d;
    logic [15:0]        acc_q, acc_d;
    logic [1:0]         step_q, step_d;
    logic               res_valid_q, res_valid_d;
    logic [15:0]        res_p_q, res_p_d;

    logic               gnt;
    logic               accept;
    logic [3:0]         mul_a, mul_b;
    logic [3:0]         shamt;
    logic [7:0]         mul_out;
    logic [15:0]        pp;

    // Grant only matters in IDLE; a tie goes to whoever did not win last time.
    always_comb begin
        if (req0_valid_i && req1_valid_i) begin
            gnt = RR_EN ? ~last_gnt_q : 1'b0;
        end else begin
            gnt = req1_valid_i;
        end
        accept = (state_q == StIdle) && (req0_valid_i || req1_valid_i);
    end

    assign req0_ready_o = accept && !gnt;
    assign req1_ready_o = accept && gnt;

    always_comb begin
        mul_a = a_q[3:0];
        mul_b = b_q[3:0];
        shamt = 4'd0;
        unique case (step_q)
            2'd0: begin mul_a = a_q[3:0]; mul_b = b_q[3:0]; shamt = 4'd0; end
            2'd1: begin mul_a = a_q[7:4]; mul_b = b_q[3:0]; shamt = 4'd4; end
            2'd2: begin mul_a = a_q[3:0]; mul_b = b_q[7:4]; shamt = 4'd4; end
            2'd3: begin mul_a = a_q[7:4]; mul_b = b_q[7:4]; shamt = 4'd8; end
        endcase
    end

    // Shared 4x4 array multiplier.
    assign mul_out = {4'b0000, mul_a} * {4'b0000, mul_b};
    assign pp      = {8'h00, mul_out} << shamt;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        tag_d       = tag_q;
        src_d       = src_q;
        last_gnt_d  = last_gnt_q;
        acc_d       = acc_q;
        step_d      = step_q;
        res_valid_d = res_valid_q;
        res_p_d     = res_p_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d        = gnt ? req1_a_i : req0_a_i;
                    b_d        = gnt ? req1_b_i : req0_b_i;
                    tag_d      = gnt ? req1_tag_i : req0_tag_i;
                    src_d      = gnt;
                    last_gnt_d = gnt;
                    acc_d      = 16'h0000;
                    step_d     = 2'd0;
                    state_d    = StStep;
                end
            end
            StStep: begin
                acc_d  = acc_q + pp;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    res_p_d     = acc_d;
                    res_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            tag_q       <= '0;
            src_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            acc_q       <= 16'h0000;
            step_q      <= 2'd0;
            res_valid_q <= 1'b0;
            res_p_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tag_q       <= tag_d;
            src_q       <= src_d;
            last_gnt_q  <= last_gnt_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            res_valid_q <= res_valid_d;
            res_p_q     <= res_p_d;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_p_o     = res_p_q;
    assign res_src_o   = src_q;
    assign res_tag_o   = tag_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mul8_share_sched.sv
// Bench for mul8_share_sched: directed scenarios plus randomized traffic against a product queue.
// A second instance with fixed priority shares the same stimulus.
module tb_mul8_share_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0]  req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
    logic [3:0]  req0_tag = 4'h0, req1_tag = 4'h0;
    logic        res_ready = 1'b1;

    logic        req0_ready, req1_ready, res_valid, res_src, busy;
    logic [15:0] res_p;
    logic [3:0]  res_tag;

    logic        fp_req0_ready, fp_req1_ready, fp_res_valid, fp_res_src, fp_busy;
    logic [15:0] fp_res_p;
    logic [3:0]  fp_res_tag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        src;
        logic [3:0]  tag;
        logic [15:0] p;
    } exp_t;

    always #5 clk = ~clk;

    mul8_share_sched #(.TAG_W(4), .RR_EN(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_tag_i(req0_tag),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_tag_i(req1_tag),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_p_o(res_p), .res_src_o(res_src), .res_tag_o(res_tag), .busy_o(busy)
    );

    mul8_share_sched #(.TAG_W(4), .RR_EN(1'b0)) u_dut_fp (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(fp_req0_ready),
        .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_tag_i(req0_tag),
        .req1_valid_i(req1_valid), .req1_ready_o(fp_req1_ready),
        .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_tag_i(req1_tag),
        .res_valid_o(fp_res_valid), .res_ready_i(res_ready),
        .res_p_o(fp_res_p), .res_src_o(fp_res_src), .res_tag_o(fp_res_tag), .busy_o(fp_busy)
    );

    // Leaves the bench just after a rising edge with reset released.
    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issues one operation and collects its result; res_ready is left as the caller set it.
    task automatic do_op(input bit src, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] tag, output logic [15:0] p, output logic s,
                         output logic [3:0] t, output int wait_cyc, output int lat,
                         output bit ok);
        ok = 1'b1;
        wait_cyc = 0;
        lat = 0;
        p = 16'h0; s = 1'b0; t = 4'h0;
        if (src) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_tag = tag;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_tag = tag;
        end
        @(negedge clk);
        while (!(src ? req1_ready : req0_ready)) begin
            if (wait_cyc > 50) begin ok = 1'b0; break; end
            @(negedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        while (!res_valid) begin
            if (lat > 50) begin ok = 1'b0; break; end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        p = res_p; s = res_src; t = res_tag;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || res_p !== 16'h0 || res_src !== 1'b0 || res_tag !== 4'h0
            || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b p=%h s=%b t=%h busy=%b, expected all zero",
                     res_valid, res_p, res_src, res_tag, busy);
        end
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_idle: got %b%b, expected 00", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_tie: got r0=%b r1=%b, expected r0=1 r1=0",
                     req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [15:0] p; logic s; logic [3:0] t; int w, lat; bit ok;
        do_reset();
        do_op(1'b0, 8'h12, 8'h34, 4'd3, p, s, t, w, lat, ok);
        checks++;
        if (!ok || p !== 16'h03A8 || s !== 1'b0 || t !== 4'd3) begin
            errors++;
            $display("FAIL single_result: got ok=%0d p=%h s=%b t=%h, expected p=03a8 s=0 t=3",
                     ok, p, s, t);
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL single_latency: got %0d, expected 4", lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p; logic s; logic [3:0] t; int w, lat; bit ok;
        do_reset();
        do_op(1'b1, 8'hFF, 8'hFF, 4'd5, p, s, t, w, lat, ok);
        checks++;
        if (!ok || p !== 16'hFE01 || s !== 1'b1 || t !== 4'd5) begin
            errors++;
            $display("FAIL b2b_first: got ok=%0d p=%h s=%b t=%h, expected p=fe01 s=1 t=5",
                     ok, p, s, t);
        end
        do_op(1'b1, 8'h00, 8'hA5, 4'd6, p, s, t, w, lat, ok);
        checks++;
        if (!ok || p !== 16'h0000 || s !== 1'b1 || t !== 4'd6) begin
            errors++;
            $display("FAIL b2b_second: got ok=%0d p=%h s=%b t=%h, expected p=0000 s=1 t=6",
                     ok, p, s, t);
        end
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL b2b_reaccept: got wait %0d, expected 0", w);
        end
    endtask

    task automatic test_round_robin();
        int g[$];
        int fpg[$];
        int n = 0;
        do_reset();
        req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h05; req0_tag = 4'h1;
        req1_valid = 1'b1; req1_a = 8'h07; req1_b = 8'h02; req1_tag = 4'h2;
        while (g.size() < 4 && n < 100) begin
            @(negedge clk);
            if (req0_ready) g.push_back(0);
            if (req1_ready) g.push_back(1);
            if (fp_req0_ready) fpg.push_back(0);
            if (fp_req1_ready) fpg.push_back(1);
            n++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (g.size() != 4) begin
            errors++;
            $display("FAIL rr_count: got %0d grants, expected 4", g.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (g[i] != (i % 2)) begin
                    errors++;
                    $display("FAIL rr_grant%0d: got %0d, expected %0d", i, g[i], i % 2);
                end
            end
        end
        checks++;
        if (fpg.size() < 3) begin
            errors++;
            $display("FAIL fp_count: got %0d grants, expected at least 3", fpg.size());
        end
        foreach (fpg[i]) begin
            checks++;
            if (fpg[i] != 0) begin
                errors++;
                $display("FAIL fp_grant%0d: got %0d, expected 0", i, fpg[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        logic [15:0] exp_p;
        int n = 0;
        do_reset();
        res_ready = 1'b0;
        exp_p = {8'h00, 8'hAB} * {8'h00, 8'hCD};
        req0_valid = 1'b1; req0_a = 8'hAB; req0_b = 8'hCD; req0_tag = 4'd9;
        @(negedge clk);
        while (!req0_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        req1_valid = 1'b1; req1_a = 8'h11; req1_b = 8'h22; req1_tag = 4'd4;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_p !== exp_p || res_src !== 1'b0 || res_tag !== 4'd9
                || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b p=%h s=%b t=%h r=%b%b, expected v=1 p=%h s=0 t=9 r=00",
                         i, res_valid, res_p, res_src, res_tag, req0_ready, req1_ready, exp_p);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || (req0_ready | req1_ready) !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume: got v=%b r=%b%b, expected v=0 one ready",
                     res_valid, req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [15:0] p; logic s; logic [3:0] t; int w, lat; bit ok;
        bit seen = 1'b0;
        int n = 0;
        do_reset();
        req0_valid = 1'b1; req0_a = 8'h80; req0_b = 8'h80; req0_tag = 4'd7;
        @(negedge clk);
        while (!req0_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req0_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res_p !== 16'h0 || res_tag !== 4'h0
            || res_src !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got busy=%b v=%b p=%h t=%h s=%b, expected all zero",
                     busy, res_valid, res_p, res_tag, res_src);
        end
        repeat (8) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrst_noresult: got res_valid=1, expected 0");
        end
        @(posedge clk);
        #1;
        do_op(1'b1, 8'h0F, 8'h11, 4'd2, p, s, t, w, lat, ok);
        checks++;
        if (!ok || p !== 16'h00FF || s !== 1'b1 || t !== 4'd2 || w != 0) begin
            errors++;
            $display("FAIL midrst_next: got ok=%0d p=%h s=%b t=%h wait=%0d, expected p=00ff s=1 t=2 wait=0",
                     ok, p, s, t, w);
        end
    endtask

    task automatic test_random();
        localparam int NOps = 2000;
        exp_t q[$];
        exp_t e;
        int accepted = 0;
        int cyc = 0;
        bit p0 = 1'b0, p1 = 1'b0;
        do_reset();
        while ((accepted < NOps || q.size() != 0) && cyc < 60000) begin
            if (!p0 && accepted < NOps && $urandom_range(0, 2) == 0) begin
                p0 = 1'b1; req0_a = 8'($urandom); req0_b = 8'($urandom);
                req0_tag = 4'($urandom);
            end else if (p0 && $urandom_range(0, 31) == 0) begin
                p0 = 1'b0;
            end
            if (!p1 && accepted < NOps && $urandom_range(0, 2) == 0) begin
                p1 = 1'b1; req1_a = 8'($urandom); req1_b = 8'($urandom);
                req1_tag = 4'($urandom);
            end else if (p1 && $urandom_range(0, 31) == 0) begin
                p1 = 1'b0;
            end
            req0_valid = p0;
            req1_valid = p1;
            res_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            checks++;
            if ((req0_ready & req1_ready) !== 1'b0 || (busy && (req0_ready | req1_ready))) begin
                errors++;
                $display("FAIL rand_ready_rule: got r=%b%b busy=%b, expected at most one ready, none when busy",
                         req0_ready, req1_ready, busy);
            end
            if (res_valid && res_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious: got result p=%h, expected none", res_p);
                end else begin
                    e = q.pop_front();
                    if (res_p !== e.p || res_src !== e.src || res_tag !== e.tag) begin
                        errors++;
                        $display("FAIL rand_result: got p=%h s=%b t=%h, expected p=%h s=%b t=%h",
                                 res_p, res_src, res_tag, e.p, e.src, e.tag);
                    end
                end
            end
            if (req0_valid && req0_ready) begin
                e.src = 1'b0; e.tag = req0_tag; e.p = {8'h00, req0_a} * {8'h00, req0_b};
                q.push_back(e); accepted++; p0 = 1'b0;
            end
            if (req1_valid && req1_ready) begin
                e.src = 1'b1; e.tag = req1_tag; e.p = {8'h00, req1_a} * {8'h00, req1_b};
                q.push_back(e); accepted++; p1 = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (accepted < NOps || q.size() != 0) begin
            errors++;
            $display("FAIL rand_complete: got %0d accepted %0d pending, expected %0d accepted 0 pending",
                     accepted, q.size(), NOps);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
